// File: rtl/dl_pkg.sv
// Shared DL11 definitions: interrupt arbiter state encoding and console defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dl_pkg;

  // Interrupt arbiter sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_PRESENT = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // DL11 console defaults, shared with the tt register blocks.
  localparam logic [7:0]  DL_CONSOLE_RX_VEC = 8'o60;
  localparam logic [7:0]  DL_CONSOLE_TX_VEC = 8'o64;
  localparam logic [12:0] DL_CONSOLE_CSR    = 13'o17560;

endpackage

// File: rtl/dl_rr_pick.sv
// Round-robin picker: first unit with rx|tx pending, scanning up from ptr with wrap.
// Latency: combinational.
// Backpressure: none; result is recomputed every cycle from the request levels.
// Ports: rx_req/tx_req per-unit request levels, ptr scan start unit;
//        valid any request found, idx winning unit, is_rx winner's rx is pending.
module dl_rr_pick #(
  parameter int NUNITS = 4,
  parameter int PW     = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic [NUNITS-1:0] rx_req,
  input  logic [NUNITS-1:0] tx_req,
  input  logic [PW-1:0]     ptr,
  output logic              valid,
  output logic [PW-1:0]     idx,
  output logic              is_rx
);

  logic [NUNITS-1:0] any_req;
  logic [PW-1:0]     u_idx;

  assign any_req = rx_req | tx_req;

  // Walk from the farthest candidate back to ptr so the nearest hit is the
  // last assignment and therefore the winner. rx beats tx inside a unit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    is_rx = 1'b0;
    u_idx = '0;
    for (int k = NUNITS - 1; k >= 0; k--) begin
      u_idx = PW'((int'(ptr) + k) % NUNITS);
      if (any_req[u_idx]) begin
        valid = 1'b1;
        idx   = u_idx;
        is_rx = rx_req[u_idx];
      end
    end
  end

endmodule

// File: rtl/dl_int_arb.sv
// Interrupt arbiter for NUNITS DL11 line units: one interrupt+vector to the CPU, ack routed back.
// Latency: request seen in IDLE -> interrupt next cycle; ack -> one-cycle unit ack next cycle.
// Backpressure: holds PRESENT until interrupt_ack or the winner withdraws; 3 cycles min per grant.
// Ports: clk, reset_n (async, active-low); rx_req/tx_req request levels; rx_ack/tx_ack ack pulses;
//        interrupt/vector to CPU (vector 0 when idle); interrupt_ack from CPU; busy = not IDLE.
module dl_int_arb
  import dl_pkg::*;
#(
  parameter int         NUNITS      = 4,
  parameter logic [7:0] BASE_VECTOR = 8'o60,
  parameter int         RR_ENABLE   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUNITS-1:0] rx_req,
  input  logic [NUNITS-1:0] tx_req,
  output logic [NUNITS-1:0] rx_ack,
  output logic [NUNITS-1:0] tx_ack,
  output logic              interrupt,
  output logic [7:0]        vector,
  input  logic              interrupt_ack,
  output logic              busy
);

  localparam int PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  arb_state_t    state, state_nxt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_unit;
  logic          win_is_rx;
  logic [7:0]    vec_q;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic          pick_is_rx;
  logic [PW-1:0] scan_ptr;
  logic          win_req;
  logic          load_win;
  logic          take_ack;

  assign scan_ptr = (RR_ENABLE != 0) ? rr_ptr : '0;

  dl_rr_pick #(
    .NUNITS (NUNITS),
    .PW     (PW)
  ) u_pick (
    .rx_req (rx_req),
    .tx_req (tx_req),
    .ptr    (scan_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx),
    .is_rx  (pick_is_rx)
  );

  // Live level of the request that won; dropping it means the unit disabled its int.
  assign win_req = win_is_rx ? rx_req[win_unit] : tx_req[win_unit];

  always_comb begin
    state_nxt = state;
    load_win  = 1'b0;
    take_ack  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          load_win  = 1'b1;
          state_nxt = ARB_PRESENT;
        end
      end
      ARB_PRESENT: begin
        // Ack beats withdrawal: the CPU has already committed to this vector.
        if (interrupt_ack) begin
          take_ack  = 1'b1;
          state_nxt = ARB_RELEASE;
        end else if (!win_req) begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      win_unit  <= '0;
      win_is_rx <= 1'b0;
      vec_q     <= '0;
      rx_ack    <= '0;
      tx_ack    <= '0;
    end else begin
      state  <= state_nxt;
      rx_ack <= '0;
      tx_ack <= '0;
      if (load_win) begin
        win_unit  <= pick_idx;
        win_is_rx <= pick_is_rx;
        // 8-bit wrap is intentional; vector space is 8 bits on this bus.
        vec_q     <= BASE_VECTOR + (8'(pick_idx) << 3) + (pick_is_rx ? 8'd0 : 8'd4);
      end
      if (take_ack) begin
        if (win_is_rx) rx_ack[win_unit] <= 1'b1;
        else           tx_ack[win_unit] <= 1'b1;
        if (RR_ENABLE != 0)
          rr_ptr <= (win_unit == PW'(NUNITS - 1)) ? '0 : win_unit + 1'b1;
      end
    end
  end

  assign interrupt = (state == ARB_PRESENT);
  assign vector    = interrupt ? vec_q : 8'd0;
  assign busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_dl_int_arb.sv
// Bench for dl_int_arb: directed stimulus, scoreboard of expected ack pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_dl_int_arb;

  logic       clk;
  logic       reset_n;
  logic [3:0] rx_req, tx_req;
  logic [3:0] rx_ack, tx_ack;
  logic       interrupt;
  logic [7:0] vector;
  logic       interrupt_ack;
  logic       busy;

  logic [3:0] fp_rx_ack, fp_tx_ack;
  logic       fp_interrupt;
  logic [7:0] fp_vector;
  logic       fp_ack;
  logic       fp_busy;

  typedef struct {
    int         unit;
    bit         is_rx;
    logic [7:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors;
  int         miscompares;
  logic [7:0] last_vec;

  dl_int_arb #(.NUNITS(4), .BASE_VECTOR(8'o60), .RR_ENABLE(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_req        (rx_req),
    .tx_req        (tx_req),
    .rx_ack        (rx_ack),
    .tx_ack        (tx_ack),
    .interrupt     (interrupt),
    .vector        (vector),
    .interrupt_ack (interrupt_ack),
    .busy          (busy)
  );

  dl_int_arb #(.NUNITS(4), .BASE_VECTOR(8'o60), .RR_ENABLE(0)) dut_fp (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_req        (rx_req),
    .tx_req        (tx_req),
    .rx_ack        (fp_rx_ack),
    .tx_ack        (fp_tx_ack),
    .interrupt     (fp_interrupt),
    .vector        (fp_vector),
    .interrupt_ack (fp_ack),
    .busy          (fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every ack pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [3:0] er, et;
    exp_t       e;
    if (interrupt) last_vec = vector;
    if ((|rx_ack) || (|tx_ack)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {24'd0, rx_ack, tx_ack}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        er = '0;
        et = '0;
        if (e.is_rx) er[e.unit] = 1'b1;
        else         et[e.unit] = 1'b1;
        chk("sb_rx_ack", {28'd0, rx_ack}, {28'd0, er});
        chk("sb_tx_ack", {28'd0, tx_ack}, {28'd0, et});
        chk("sb_vector", {24'd0, last_vec}, {24'd0, e.vec});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int();
    int n = 0;
    while (interrupt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_interrupt", {31'd0, interrupt}, 32'd1);
  endtask

  // clr: 0 keep request, 1 drop it during RELEASE, 2 drop it together with the ack.
  task automatic grant(input int unit, input bit is_rx, input logic [7:0] vec, input int clr);
    exp_t e;
    e.unit  = unit;
    e.is_rx = is_rx;
    e.vec   = vec;
    exp_q.push_back(e);
    wait_int();
    interrupt_ack = 1'b1;
    if (clr == 2) begin
      if (is_rx) rx_req[unit] = 1'b0;
      else       tx_req[unit] = 1'b0;
    end
    tick();
    interrupt_ack = 1'b0;
    if (clr == 1) begin
      if (is_rx) rx_req[unit] = 1'b0;
      else       tx_req[unit] = 1'b0;
    end
    tick();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    last_vec      = '0;
    reset_n       = 1'b0;
    rx_req        = 4'b0100;
    tx_req        = 4'b0000;
    interrupt_ack = 1'b0;
    fp_ack        = 1'b0;

    // Reset state, with a request already pending.
    tick();
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("rst_vector", {24'd0, vector}, 32'd0);
    chk("rst_acks", {24'd0, rx_ack, tx_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    chk("rel_interrupt", {31'd0, interrupt}, 32'd0);
    tick();
    chk("first_interrupt", {31'd0, interrupt}, 32'd1);
    chk("first_vector", {24'd0, vector}, {24'd0, 8'o100});
    chk("first_busy", {31'd0, busy}, 32'd1);
    grant(2, 1'b1, 8'o100, 1);
    chk("post_ack_interrupt", {31'd0, interrupt}, 32'd0);
    chk("post_ack_vector", {24'd0, vector}, 32'd0);

    // rx beats tx within a unit.
    rx_req[1] = 1'b1;
    tx_req[1] = 1'b1;
    grant(1, 1'b1, 8'o70, 1);
    grant(1, 1'b0, 8'o74, 1);

    // Round-robin fairness with everything requesting.
    reset_pulse();
    rx_req = 4'b1111;
    tx_req = 4'b1111;
    grant(0, 1'b1, 8'o60, 0);
    grant(1, 1'b1, 8'o70, 0);
    grant(2, 1'b1, 8'o100, 0);
    grant(3, 1'b1, 8'o110, 0);
    grant(0, 1'b1, 8'o60, 0);
    rx_req = 4'b0000;
    tx_req = 4'b0000;
    tick();
    tick();

    // Fixed priority instance: unit 0 rx every time.
    reset_pulse();
    rx_req = 4'b1111;
    tx_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (fp_interrupt !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("fp_interrupt", {31'd0, fp_interrupt}, 32'd1);
      chk("fp_vector", {24'd0, fp_vector}, {24'd0, 8'o60});
      fp_ack = 1'b1;
      tick();
      fp_ack = 1'b0;
      chk("fp_rx_ack", {28'd0, fp_rx_ack}, 32'd1);
      chk("fp_tx_ack", {28'd0, fp_tx_ack}, 32'd0);
      tick();
    end
    rx_req = 4'b0000;
    tx_req = 4'b0000;
    tick();
    tick();

    // Withdrawal without ack leaves rr_ptr at 0.
    reset_pulse();
    tx_req[0] = 1'b1;
    wait_int();
    chk("wd_vector", {24'd0, vector}, {24'd0, 8'o64});
    tx_req[0] = 1'b0;
    tick();
    chk("wd_interrupt", {31'd0, interrupt}, 32'd0);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    tick();
    rx_req = 4'b0011;
    grant(0, 1'b1, 8'o60, 1);
    grant(1, 1'b1, 8'o70, 1);
    // Withdrawal coinciding with ack still acks.
    tx_req[0] = 1'b1;
    grant(0, 1'b0, 8'o64, 2);

    // Reset between interrupt_ack and the ack pulse.
    rx_req[3] = 1'b1;
    wait_int();
    chk("mid_vector", {24'd0, vector}, {24'd0, 8'o110});
    interrupt_ack = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("mid_rst_vector", {24'd0, vector}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_acks", {24'd0, rx_ack, tx_ack}, 32'd0);
    interrupt_ack = 1'b0;
    rx_req = 4'b0000;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_after_busy", {31'd0, busy}, 32'd0);
    chk("mid_after_interrupt", {31'd0, interrupt}, 32'd0);

    // Stray ack while idle.
    interrupt_ack = 1'b1;
    tick();
    tick();
    interrupt_ack = 1'b0;
    chk("idle_ack_interrupt", {31'd0, interrupt}, 32'd0);
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
